alu_issue_ctrl: RTL

- Operand-fetch, issue and write-back controller that sits directly upstream and downstream of the 16-bit registered ALU (`alu`).
- Holds an 8 x 16 register file and accepts 3-operand instructions over a valid/ready handshake.
- Presents operands, op code and enable to the ALU, captures the ALU result and flags one cycle later, and writes the result back to the destination register.
- A host load port preloads registers; a read port exposes register contents to the host and the bench.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu.sv | 75 +++++++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and its issue controller: widths, op codes,
// instruction field positions, FSM states and flag bit indices.
package alu_pkg;

   localparam int ALU_DATA_W  = 16;
   localparam int ALU_RADDR_W = 3;
   localparam int ALU_OP_W    = 4;
   localparam int INSTR_W     = 16;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;

   // Least-significant bit of each instruction field; bits [2:0] are unused.
   localparam int INSTR_OP_LSB  = 12;
   localparam int INSTR_RD_LSB  = 9;
   localparam int INSTR_RS1_LSB = 6;
   localparam int INSTR_RS2_LSB = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_e;

   localparam int FLAG_ZERO  = 2;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/alu.sv
// Registered 16-bit ALU: samples operands when enabled and presents result and flags
// after that edge. SUB reports borrow on carry; unknown op codes return zero.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              carry,
   output logic              overflow
);

   logic [DATA_W:0]   sum, diff;
   logic [DATA_W-1:0] result_d, result_q;
   logic              zero_d, zero_q, carry_d, carry_q, overflow_d, overflow_q;

   // NOTE: every variable assigned here gets a default first, so no path leaves a latch.
   always_comb begin
      sum        = {1'b0, a} + {1'b0, b};
      diff       = {1'b0, a} - {1'b0, b};
      result_d   = result_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      if (enable) begin
         carry_d    = 1'b0;
         overflow_d = 1'b0;
         case (op)
            OP_ADD: begin
               result_d   = sum[DATA_W-1:0];
               carry_d    = sum[DATA_W];
               overflow_d = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
               result_d   = diff[DATA_W-1:0];
               carry_d    = diff[DATA_W];
               overflow_d = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:  result_d = a & b;
            default: result_d = '0;
         endcase
         zero_d = (result_d == '0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         result_q   <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         result_q   <= result_d;
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign carry    = carry_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/alu_regfile.sv
// 2**RADDR_W x DATA_W register file: one synchronous write port, three combinational
// read ports, synchronous clear on reset.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int DATA_W  = ALU_DATA_W,
   parameter int RADDR_W = ALU_RADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [RADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [RADDR_W-1:0] ra1,
   input  logic [RADDR_W-1:0] ra2,
   input  logic [RADDR_W-1:0] ra3,
   output logic [DATA_W-1:0]  rd1,
   output logic [DATA_W-1:0]  rd2,
   output logic [DATA_W-1:0]  rd3
);

   localparam int DEPTH = 2 ** RADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];

   // NOTE: the array is cleared on reset because software relies on every register
   // reading 0 afterwards; that rules out inferring a RAM macro for this storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else if (we) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rd1 = regs_q[ra1];
   assign rd2 = regs_q[ra2];
   assign rd3 = regs_q[ra3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand-fetch / issue / write-back controller for the registered ALU. A three-state
// FSM gives one instruction per three cycles, so dependent instructions need no hazard logic.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W  = ALU_DATA_W,
   parameter int RADDR_W = ALU_RADDR_W,
   parameter int OP_W    = ALU_OP_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic               ld_en,
   input  logic [RADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0]  ld_data,
   input  logic [RADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0]  rd_data,
   output logic               alu_enable,
   output logic [OP_W-1:0]    alu_op,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               alu_zero,
   input  logic               alu_carry,
   input  logic               alu_overflow,
   output logic               wb_valid,
   output logic [RADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   output logic [2:0]         flags,
   output logic               busy
);

   state_e             state_d, state_q;
   logic [OP_W-1:0]    alu_op_d, alu_op_q;
   logic [DATA_W-1:0]  alu_a_d, alu_a_q, alu_b_d, alu_b_q;
   logic               alu_enable_d, alu_enable_q;
   logic [RADDR_W-1:0] rd_d, rd_q;
   logic               wb_valid_d, wb_valid_q;
   logic [RADDR_W-1:0] wb_addr_d, wb_addr_q;
   logic [DATA_W-1:0]  wb_data_d, wb_data_q;
   logic [2:0]         flags_d, flags_q;
   logic               busy_d, busy_q;

   logic               rf_we;
   logic [RADDR_W-1:0] rf_waddr, rs1, rs2, rd_fld;
   logic [DATA_W-1:0]  rf_wdata, rs1_data, rs2_data;
   logic               unused_instr_bits;

   assign rs1               = instr[INSTR_RS1_LSB +: RADDR_W];
   assign rs2               = instr[INSTR_RS2_LSB +: RADDR_W];
   assign rd_fld            = instr[INSTR_RD_LSB +: RADDR_W];
   assign unused_instr_bits = ^instr[2:0];

   alu_regfile #(
      .DATA_W  (DATA_W),
      .RADDR_W (RADDR_W)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (rf_we),
      .waddr (rf_waddr),
      .wdata (rf_wdata),
      .ra1   (rs1),
      .ra2   (rs2),
      .ra3   (rd_addr),
      .rd1   (rs1_data),
      .rd2   (rs2_data),
      .rd3   (rd_data)
   );

   always_comb begin
      state_d      = state_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_enable_d = 1'b0;
      rd_d         = rd_q;
      wb_valid_d   = 1'b0;
      wb_addr_d    = wb_addr_q;
      wb_data_d    = wb_data_q;
      flags_d      = flags_q;
      rf_we        = 1'b0;
      rf_waddr     = ld_addr;
      rf_wdata     = ld_data;
      case (state_q)
         IDLE: begin
            // Host load shares the write port; operands below still see pre-write data.
            rf_we = ld_en;
            if (instr_valid) begin
               alu_a_d      = rs1_data;
               alu_b_d      = rs2_data;
               alu_op_d     = instr[INSTR_OP_LSB +: OP_W];
               rd_d         = rd_fld;
               alu_enable_d = 1'b1;
               state_d      = EXEC;
            end
         end
         EXEC: state_d = WB;
         WB: begin
            rf_we               = 1'b1;
            rf_waddr            = rd_q;
            rf_wdata            = alu_result;
            wb_valid_d          = 1'b1;
            wb_addr_d           = rd_q;
            wb_data_d           = alu_result;
            flags_d[FLAG_ZERO]  = alu_zero;
            flags_d[FLAG_CARRY] = alu_carry;
            flags_d[FLAG_OVF]   = alu_overflow;
            state_d             = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_enable_q <= 1'b0;
         rd_q         <= '0;
         wb_valid_q   <= 1'b0;
         wb_addr_q    <= '0;
         wb_data_q    <= '0;
         flags_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_enable_q <= alu_enable_d;
         rd_q         <= rd_d;
         wb_valid_q   <= wb_valid_d;
         wb_addr_q    <= wb_addr_d;
         wb_data_q    <= wb_data_d;
         flags_q      <= flags_d;
         busy_q       <= busy_d;
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign alu_enable  = alu_enable_q;
   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign wb_valid    = wb_valid_q;
   assign wb_addr     = wb_addr_q;
   assign wb_data     = wb_data_q;
   assign flags       = flags_q;
   assign busy        = busy_q;

endmodule
